// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, scale encodings and irq bit indices
package vga_pkg;

    // 1024x768@60 CVT raster
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 104;
    localparam int DEF_H_BP     = 152;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        SCALE_1X     = 2'd0,
        SCALE_2X     = 2'd1,
        SCALE_4X     = 2'd2,
        SCALE_4X_ALT = 2'd3
    } scale_e;

    localparam int IRQ_FRAME = 0;
    localparam int IRQ_LINE  = 1;

    // Terminal value of the sub-pixel prescaler; the unused code 3 behaves as 4x
    function automatic logic [1:0] scale_mask(input logic [1:0] s);
        case (s)
            SCALE_1X: scale_mask = 2'd0;
            SCALE_2X: scale_mask = 2'd1;
            default:  scale_mask = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/vga_cell_counter.sv
// rtl/vga_cell_counter.sv - prescaled lo/hi character-cell counter for one raster axis
module vga_cell_counter
    import vga_pkg::*;
#(
    parameter int CELL = 32,
    parameter int LO_W = 5,
    parameter int HI_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [1:0]      scale,
    output logic [LO_W-1:0] lo,
    output logic [HI_W-1:0] hi
);

    localparam logic [LO_W-1:0] LO_LAST = LO_W'(CELL - 1);

    logic [1:0] sub;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sub <= '0;
            lo  <= '0;
            hi  <= '0;
        end else if (en) begin
            if (sub == scale_mask(scale)) begin
                sub <= '0;
                if (lo == LO_LAST) begin
                    lo <= '0;
                    hi <= hi + 1'b1;
                end else begin
                    lo <= lo + 1'b1;
                end
            end else begin
                sub <= sub + 2'd1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with scaled cell coordinates and sticky interrupts
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b1,
    parameter int   CELL_W   = 32,
    parameter int   CELL_H   = 48,
    parameter int   HW       = 11,
    parameter int   VW       = 10,
    parameter int   XHI_W    = 6,
    parameter int   XLO_W    = 5,
    parameter int   YHI_W    = 5,
    parameter int   YLO_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       scale,
    input  logic [VW-1:0]    line_cmp,
    input  logic             frame_ie,
    input  logic             line_ie,
    input  logic [1:0]       irq_clr,
    output logic [HW-1:0]    x_raw,
    output logic [VW-1:0]    y_raw,
    output logic [XHI_W-1:0] x_hi,
    output logic [XLO_W-1:0] x_lo,
    output logic [YHI_W-1:0] y_hi,
    output logic [YLO_W-1:0] y_lo,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start,
    output logic             irq_frame,
    output logic             irq_line,
    output logic             irq
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOT > (1 << HW)) begin : g_h_too_wide
            $error("vga_timing_gen: H_TOT does not fit in HW bits");
        end
        if (V_TOT > (1 << VW)) begin : g_v_too_wide
            $error("vga_timing_gen: V_TOT does not fit in VW bits");
        end
    endgenerate

    logic [HW-1:0] x_nxt;
    logic [VW-1:0] y_nxt;
    logic          x_wrap;
    logic          frame_wrap;
    logic [1:0]    scale_q;

    always_comb begin
        x_wrap     = (x_raw == H_LAST);
        frame_wrap = x_wrap && (y_raw == V_LAST);
        x_nxt      = x_wrap ? '0 : x_raw + 1'b1;
        y_nxt      = y_raw;
        if (x_wrap) begin
            y_nxt = (y_raw == V_LAST) ? '0 : y_raw + 1'b1;
        end
    end

    // Window outputs are decoded from the next position so they land with x_raw/y_raw
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_raw       <= '0;
            y_raw       <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            blank       <= 1'b0;
            frame_start <= 1'b1;
            scale_q     <= 2'd0;
            irq_frame   <= 1'b0;
            irq_line    <= 1'b0;
        end else begin
            x_raw       <= x_nxt;
            y_raw       <= y_nxt;
            hsync       <= (x_nxt >= HS_START && x_nxt < HS_END) ? H_POL : ~H_POL;
            vsync       <= (y_nxt >= VS_START && y_nxt < VS_END) ? V_POL : ~V_POL;
            blank       <= (x_nxt >= H_ACT) || (y_nxt >= V_ACT);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                scale_q <= scale;
            end
            // A set in the same cycle as its clear wins so no event is lost
            irq_frame <= (frame_wrap && frame_ie) ||
                         (irq_frame && !irq_clr[IRQ_FRAME]);
            irq_line  <= (x_nxt == H_ACT && y_raw == line_cmp && line_ie) ||
                         (irq_line && !irq_clr[IRQ_LINE]);
        end
    end

    assign irq = irq_frame | irq_line;

    vga_cell_counter #(
        .CELL (CELL_W),
        .LO_W (XLO_W),
        .HI_W (XHI_W)
    ) u_x_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (x_wrap),
        .en    (x_nxt < H_ACT),
        .scale (scale_q),
        .lo    (x_lo),
        .hi    (x_hi)
    );

    vga_cell_counter #(
        .CELL (CELL_H),
        .LO_W (YLO_W),
        .HI_W (YHI_W)
    ) u_y_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_wrap),
        .en    (x_wrap && (y_nxt < V_ACT)),
        .scale (scale_q),
        .lo    (y_lo),
        .hi    (y_hi)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen, default and small raster builds
module tb_vga_timing_gen;

    localparam int SH = 16;
    localparam int SV = 8;
    localparam int SF = SH * SV;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  d_scale, d_irq_clr;
    logic [9:0]  d_line_cmp;
    logic        d_frame_ie, d_line_ie;
    logic [10:0] d_x_raw;
    logic [9:0]  d_y_raw;
    logic [5:0]  d_x_hi;
    logic [4:0]  d_x_lo;
    logic [4:0]  d_y_hi;
    logic [5:0]  d_y_lo;
    logic        d_hsync, d_vsync, d_blank, d_frame_start, d_irq_frame, d_irq_line, d_irq;

    logic [1:0]  s_scale, s_irq_clr;
    logic [2:0]  s_line_cmp;
    logic        s_frame_ie, s_line_ie;
    logic [3:0]  s_x_raw;
    logic [2:0]  s_y_raw;
    logic [1:0]  s_x_hi, s_x_lo, s_y_hi;
    logic        s_y_lo;
    logic        s_hsync, s_vsync, s_blank, s_frame_start, s_irq_frame, s_irq_line, s_irq;

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .scale(d_scale), .line_cmp(d_line_cmp),
        .frame_ie(d_frame_ie), .line_ie(d_line_ie), .irq_clr(d_irq_clr),
        .x_raw(d_x_raw), .y_raw(d_y_raw), .x_hi(d_x_hi), .x_lo(d_x_lo),
        .y_hi(d_y_hi), .y_lo(d_y_lo), .hsync(d_hsync), .vsync(d_vsync),
        .blank(d_blank), .frame_start(d_frame_start), .irq_frame(d_irq_frame),
        .irq_line(d_irq_line), .irq(d_irq)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CELL_W(3), .CELL_H(2),
        .HW(4), .VW(3), .XHI_W(2), .XLO_W(2), .YHI_W(2), .YLO_W(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .scale(s_scale), .line_cmp(s_line_cmp),
        .frame_ie(s_frame_ie), .line_ie(s_line_ie), .irq_clr(s_irq_clr),
        .x_raw(s_x_raw), .y_raw(s_y_raw), .x_hi(s_x_hi), .x_lo(s_x_lo),
        .y_hi(s_y_hi), .y_lo(s_y_lo), .hsync(s_hsync), .vsync(s_vsync),
        .blank(s_blank), .frame_start(s_frame_start), .irq_frame(s_irq_frame),
        .irq_line(s_irq_line), .irq(s_irq)
    );

    // Reference for the small build: linear position in the frame, frame scale and pending irqs
    int         m_pos;
    logic [1:0] m_scale;
    logic       m_irq_f, m_irq_l;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos   <= 0;
            m_scale <= 2'd0;
            m_irq_f <= 1'b0;
            m_irq_l <= 1'b0;
        end else begin
            m_pos <= (m_pos + 1) % SF;
            if ((m_pos + 1) % SF == 0) m_scale <= s_scale;
            m_irq_f <= (((m_pos + 1) % SF == 0) && s_frame_ie) || (m_irq_f && !s_irq_clr[0]);
            m_irq_l <= (((m_pos + 1) % SH == 8) && (m_pos / SH == int'(s_line_cmp)) && s_line_ie)
                       || (m_irq_l && !s_irq_clr[1]);
        end
    end

    function automatic int shift_of(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (d_x_raw !== 11'd0 || d_y_raw !== 10'd0) begin errors++;
            $display("FAIL reset_pos_dflt: got x=%0d y=%0d expected 0,0", d_x_raw, d_y_raw); end
        checks++; if ({d_frame_start, d_hsync, d_vsync, d_blank} !== 4'b1100) begin errors++;
            $display("FAIL reset_sync_dflt: got fs,hs,vs,bl=%b expected 1100", {d_frame_start, d_hsync, d_vsync, d_blank}); end
        checks++; if ({d_x_hi, d_x_lo, d_y_hi, d_y_lo, d_irq_frame, d_irq_line, d_irq} !== 25'd0) begin errors++;
            $display("FAIL reset_cells_irq_dflt: got %h expected 0", {d_x_hi, d_x_lo, d_y_hi, d_y_lo, d_irq_frame, d_irq_line, d_irq}); end
        checks++; if ({s_frame_start, s_hsync, s_vsync, s_blank} !== 4'b1010) begin errors++;
            $display("FAIL reset_sync_small: got fs,hs,vs,bl=%b expected 1010", {s_frame_start, s_hsync, s_vsync, s_blank}); end
        rst_n = 1'b1;
    endtask

    task automatic test_default_line();
        int x, y, lx;
        for (int k = 1; k <= 1328; k++) begin
            @(negedge clk);
            x = k % 1328;
            y = k / 1328;
            lx = (x < 1024) ? x : 1023;
            checks++; if (d_x_raw !== 11'(x) || d_y_raw !== 10'(y)) begin errors++;
                $display("FAIL dflt_pos: got x=%0d y=%0d expected %0d,%0d", d_x_raw, d_y_raw, x, y); end
            checks++; if (d_hsync !== ((x >= 1072 && x < 1176) ? 1'b0 : 1'b1) || d_vsync !== 1'b0) begin errors++;
                $display("FAIL dflt_sync at x=%0d: got hs=%b vs=%b", x, d_hsync, d_vsync); end
            checks++; if (d_blank !== (x >= 1024) || d_frame_start !== 1'b0) begin errors++;
                $display("FAIL dflt_blank at x=%0d: got blank=%b fs=%b", x, d_blank, d_frame_start); end
            checks++; if (d_x_hi !== 6'(lx / 32) || d_x_lo !== 5'(lx % 32)) begin errors++;
                $display("FAIL dflt_xcell at x=%0d: got %0d/%0d expected %0d/%0d", x, d_x_hi, d_x_lo, lx / 32, lx % 32); end
            checks++; if (d_y_hi !== 5'd0 || d_y_lo !== 6'(y)) begin errors++;
                $display("FAIL dflt_ycell at x=%0d: got %0d/%0d expected 0/%0d", x, d_y_hi, d_y_lo, y); end
            checks++; if (d_irq_line !== (k >= 1024) || d_irq !== (k >= 1024) || d_irq_frame !== 1'b0) begin errors++;
                $display("FAIL dflt_irq at k=%0d: got line=%b irq=%b frame=%b", k, d_irq_line, d_irq, d_irq_frame); end
        end
    endtask

    task automatic test_small_windows();
        int ex, ey;
        for (int c = 0; c < 2 * SF; c++) begin
            @(negedge clk);
            ex = m_pos % SH;
            ey = m_pos / SH;
            checks++; if (s_x_raw !== 4'(ex) || s_y_raw !== 3'(ey)) begin errors++;
                $display("FAIL small_pos: got %0d,%0d expected %0d,%0d", s_x_raw, s_y_raw, ex, ey); end
            checks++; if (s_hsync !== (ex >= 10 && ex < 13) || s_vsync !== !(ey >= 5 && ey < 7)) begin errors++;
                $display("FAIL small_sync at %0d,%0d: got hs=%b vs=%b", ex, ey, s_hsync, s_vsync); end
            checks++; if (s_blank !== (ex >= 8 || ey >= 4) || s_frame_start !== (m_pos == 0)) begin errors++;
                $display("FAIL small_blank_fs at %0d,%0d: got blank=%b fs=%b", ex, ey, s_blank, s_frame_start); end
        end
    endtask

    task automatic test_small_cells();
        int ex, ey, lx, ly;
        for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(10, 100)) @(negedge clk);
            s_scale = 2'(s);
            for (int c = 0; c < 2 * SF; c++) begin
                @(negedge clk);
                ex = m_pos % SH;
                ey = m_pos / SH;
                lx = ((ex < 8) ? ex : 7) >> shift_of(m_scale);
                ly = ((ey < 4) ? ey : 3) >> shift_of(m_scale);
                checks++; if (s_x_hi !== 2'(lx / 3) || s_x_lo !== 2'(lx % 3)) begin errors++;
                    $display("FAIL small_xcell s=%0d at %0d,%0d: got %0d/%0d expected %0d/%0d", s, ex, ey, s_x_hi, s_x_lo, lx / 3, lx % 3); end
                checks++; if (s_y_hi !== 2'(ly / 2) || s_y_lo !== 1'(ly % 2)) begin errors++;
                    $display("FAIL small_ycell s=%0d at %0d,%0d: got %0d/%0d expected %0d/%0d", s, ex, ey, s_y_hi, s_y_lo, ly / 2, ly % 2); end
            end
        end
    endtask

    task automatic test_irq_frame();
        s_frame_ie = 1'b1;
        for (int c = 0; c < 3 * SF; c++) begin
            @(negedge clk);
            checks++; if (s_irq_frame !== m_irq_f || s_irq !== (m_irq_f | m_irq_l)) begin errors++;
                $display("FAIL irq_frame at pos %0d: got %b/%b expected %b", m_pos, s_irq_frame, s_irq, m_irq_f); end
            if (m_pos == 0) begin
                checks++; if (s_irq_frame !== 1'b1) begin errors++;
                    $display("FAIL irq_frame_set_at_origin: got %b expected 1", s_irq_frame); end
            end
            s_irq_clr = ($urandom % 40 == 0) ? 2'b01 : 2'b00;
            if (m_pos == SF - 1 && c > SF) s_irq_clr = 2'b01;
        end
        s_irq_clr  = 2'b00;
        s_frame_ie = 1'b0;
        for (int c = 0; c < SF; c++) begin
            @(negedge clk);
            checks++; if (s_irq_frame !== m_irq_f) begin errors++;
                $display("FAIL irq_frame_hold at pos %0d: got %b expected %b", m_pos, s_irq_frame, m_irq_f); end
        end
    endtask

    task automatic test_irq_line();
        logic [2:0] cmps [5] = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd3};
        for (int i = 0; i < 5; i++) begin
            s_line_cmp = cmps[i];
            s_line_ie  = 1'b1;
            s_irq_clr  = 2'b10;
            for (int c = 0; c < SF + 20; c++) begin
                @(negedge clk);
                checks++; if (s_irq_line !== m_irq_l || s_irq !== (m_irq_f | m_irq_l)) begin errors++;
                    $display("FAIL irq_line cmp=%0d pos=%0d: got %b/%b expected %b", s_line_cmp, m_pos, s_irq_line, s_irq, m_irq_l); end
                s_irq_clr = ($urandom % 30 == 0) ? 2'b10 : 2'b00;
                if (c == SF / 2) s_line_ie = 1'($urandom % 2);
            end
        end
        s_irq_clr = 2'b00;
    endtask

    task automatic test_reset_midframe();
        s_frame_ie = 1'b1;
        repeat (SF + $urandom_range(20, 100)) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (s_x_raw !== 4'd0 || s_y_raw !== 3'd0 || s_frame_start !== 1'b1) begin errors++;
            $display("FAIL reset_midframe_pos: got %0d,%0d fs=%b expected 0,0,1", s_x_raw, s_y_raw, s_frame_start); end
        checks++; if (s_irq_frame !== 1'b0 || s_irq_line !== 1'b0 || s_x_hi !== 2'd0) begin errors++;
            $display("FAIL reset_midframe_state: got irqf=%b irql=%b xhi=%0d expected 0", s_irq_frame, s_irq_line, s_x_hi); end
        for (int c = 0; c < SF; c++) begin
            @(negedge clk);
            checks++; if (s_x_raw !== 4'(m_pos % SH) || s_y_raw !== 3'(m_pos / SH)) begin errors++;
                $display("FAIL reset_midframe_run: got %0d,%0d expected %0d,%0d", s_x_raw, s_y_raw, m_pos % SH, m_pos / SH); end
        end
    endtask

    task automatic test_random();
        int ex, ey, lx, ly;
        for (int c = 0; c < 20 * SF; c++) begin
            @(negedge clk);
            ex = m_pos % SH;
            ey = m_pos / SH;
            lx = ((ex < 8) ? ex : 7) >> shift_of(m_scale);
            ly = ((ey < 4) ? ey : 3) >> shift_of(m_scale);
            checks++; if (s_x_raw !== 4'(ex) || s_y_raw !== 3'(ey) || s_blank !== (ex >= 8 || ey >= 4)) begin errors++;
                $display("FAIL rand_pos: got %0d,%0d blank=%b expected %0d,%0d", s_x_raw, s_y_raw, s_blank, ex, ey); end
            checks++; if ({s_x_hi, s_x_lo, s_y_hi, s_y_lo} !== {2'(lx / 3), 2'(lx % 3), 2'(ly / 2), 1'(ly % 2)}) begin errors++;
                $display("FAIL rand_cells at %0d,%0d: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d", ex, ey, s_x_hi, s_x_lo, s_y_hi, s_y_lo, lx / 3, lx % 3, ly / 2, ly % 2); end
            checks++; if (s_irq_frame !== m_irq_f || s_irq_line !== m_irq_l || s_irq !== (m_irq_f | m_irq_l)) begin errors++;
                $display("FAIL rand_irq at %0d,%0d: got %b%b%b expected %b%b", ex, ey, s_irq_frame, s_irq_line, s_irq, m_irq_f, m_irq_l); end
            s_irq_clr = ($urandom % 8 == 0) ? 2'($urandom) : 2'b00;
            if ($urandom % 50 == 0) s_scale = 2'($urandom);
            if ($urandom % 60 == 0) s_line_cmp = 3'($urandom);
            if ($urandom % 40 == 0) s_frame_ie = 1'($urandom);
            if ($urandom % 40 == 0) s_line_ie = 1'($urandom);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        d_scale    = 2'd0;
        d_irq_clr  = 2'b00;
        d_line_cmp = 10'd0;
        d_frame_ie = 1'b1;
        d_line_ie  = 1'b1;
        s_scale    = 2'd0;
        s_irq_clr  = 2'b00;
        s_line_cmp = 3'd0;
        s_frame_ie = 1'b0;
        s_line_ie  = 1'b0;
        test_reset();
        test_default_line();
        test_small_windows();
        test_small_cells();
        test_irq_frame();
        test_irq_line();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the VGA console.
- Active, porch and sync extents are parameters; sync polarities are selectable.
- Outputs split character-cell coordinates, with a runtime pixel-scaling mode (1x/2x/4x).
- Two sticky interrupt sources (frame start, raster-line compare) with per-source enable and clear; feeds the text/glyph pipeline and the CPU interrupt line.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 104, horizontal sync width
- H_BP, 152, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- H_POL, 0, hsync asserted level
- V_POL, 1, vsync asserted level
- CELL_W, 32, cell width in logical pixels
- CELL_H, 48, cell height in logical lines
- HW, 11, raw x counter width
- VW, 10, raw y counter width
- XHI_W / XLO_W / YHI_W / YLO_W, 6/5/5/6, cell-coordinate widths

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- scale  in  2  0=1x, 1=2x, 2=4x, 3=treated as 4x
- line_cmp  in  VW  raw line number for the line interrupt
- frame_ie  in  1  frame interrupt enable
- line_ie  in  1  line interrupt enable
- irq_clr  in  2  bit0 clears irq_frame, bit1 clears irq_line (one-cycle strobes)
- x_raw  out  HW  raw pixel column
- y_raw  out  VW  raw line
- x_hi  out  XHI_W  logical cell column
- x_lo  out  XLO_W  logical pixel within cell
- y_hi  out  YHI_W  logical cell row
- y_lo  out  YLO_W  logical line within cell
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- blank  out  1  high outside the active area
- frame_start  out  1  one-cycle pulse while position is (0,0)
- irq_frame  out  1  sticky frame interrupt
- irq_line  out  1  sticky line interrupt
- irq  out  1  irq_frame | irq_line

Behaviour:
- Totals: H_TOT = sum of H parameters (1328); V_TOT = sum of V parameters (798).
- Counters: x_raw increments every clk and wraps H_TOT-1 -> 0. y_raw increments on each x wrap and wraps V_TOT-1 -> 0.
- Sync and blank windows:
  - hsync = H_POL when x_raw is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise the inverse.
  - vsync = V_POL when y_raw is in [V_ACTIVE+V_FP, +V_SYNC); otherwise the inverse.
  - blank = (x_raw >= H_ACTIVE) | (y_raw >= V_ACTIVE).
- Alignment: hsync, vsync and blank are registered and computed from next-state counters, so they are aligned with x_raw/y_raw in the same cycle (no skew).
- Scale sampling: scale is captured into scale_q only on the cycle entering (0,0). A mid-frame change takes effect at the next frame.
- Logical x: a sub-pixel counter counts 2^scale_q raw pixels.
  - On rollover while x_raw < H_ACTIVE: x_lo increments; at CELL_W-1 it wraps to 0 and x_hi increments.
  - Outside the active region the logical x counters hold.
  - All x logical state resets to 0 on every x wrap.
- Logical y: same scheme per line at x wrap, advancing only while the new y_raw < V_ACTIVE. All y logical state resets at frame wrap.
- No dividers or multipliers in the cell-coordinate logic; it is incremental counters only.
- irq_frame: set on the cycle entering (0,0) if frame_ie.
- irq_line: set on the cycle entering x_raw == H_ACTIVE when y_raw == line_cmp, if line_ie.
- Interrupt persistence: both are sticky until their irq_clr bit is seen. When set and clear coincide, set wins (no lost event). Deasserting an enable does not clear a pending interrupt.
- line_cmp >= V_ACTIVE is legal; it fires in vertical blanking. line_cmp >= V_TOT never fires.
- Reset values: all counters 0, scale_q 0, irq_* 0, frame_start 1.
  - hsync = ~H_POL, vsync = ~V_POL, blank 0, i.e. the values for position (0,0).
  - Reset mid-frame restarts at (0,0) on the next cycle.
- Elaboration check: the design must flag an error if H_TOT > 2^HW or V_TOT > 2^VW.

Decomposition:
- Shared package vga_pkg holds:
  - the default 1024x768@60 CVT timing constants;
  - scale encodings;
  - irq bit indices IRQ_FRAME=0, IRQ_LINE=1.
- One natural sub-module, vga_cell_counter: prescaler plus lo/hi cell counter with enable, clear and scale. It is instantiated twice, for the x and y axes.

Test Plan:
- Reset with defaults -> x_raw=y_raw=0, frame_start=1, hsync=1, vsync=0, blank=0. After 1328 clocks x_raw=0 and y_raw=1.
- Hsync window -> hsync low exactly for x_raw 1072..1175. vsync high exactly for y_raw 771..774. blank rises at x_raw=1024 and at y_raw=768.
- scale=0, 1x -> x_hi=1, x_lo=0 at x_raw=32. At y_raw=48: y_hi=1, y_lo=0. At x_raw=1023: x_hi=31, x_lo=31.
- scale=1 written mid-frame -> no change until the next (0,0). Then x_lo steps every 2 clocks, x_hi=1 at x_raw=64, and y_hi=1 at y_raw=96.
- frame_ie=1 -> irq_frame rises at (0,0) and holds across the frame. An irq_clr[0] pulse drops it. A clear coincident with (0,0) leaves it set.
- line_ie=1, line_cmp=100 -> irq_line rises at y_raw=100, x_raw=1024, and irq=1. line_cmp=900 -> never fires. Small-timing build (H_ACTIVE=8, V_ACTIVE=4) -> totals and sync windows match the parameters.
